mult_18x18_share_arbiter: RTL and testbench
===========================================

Name: mult_18x18_share_arbiter

Overview:
- Sequences and shares one fracturable 18x18 multiplier core (frac_mult_18_18 datapath: A, B, MODE in; Y out) between two user-logic requesters.
- Registers the operands and drives the core's MODE bit (0 = one 18x18 product, 1 = two 9x9 lane products).
- Captures the product after a parameterised number of cycles and returns it on a per-requester response channel.
- Sits in the user clock domain beside the mult_18 logical tile.

Parameters:
- PIPE_STAGES, 1, cycles from registered operands on mult_A/mult_B to a valid mult_Y sample; legal range 1..4.

Ports:
- clk  input  1  user clock; all state on its rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- req0_valid / req1_valid  input  1  request present.
- req0_ready / req1_ready  output  1  request accepted this cycle when valid&ready.
- req0_mode / req1_mode  input  1  0 = 18x18, 1 = 9x9.
- req0_a, req0_b, req1_a, req1_b  input  18 each  unsigned operands; in 9x9 mode only bits [8:0] are used.
- rsp0_valid / rsp1_valid  output  1  result held.
- rsp0_ready / rsp1_ready  input  1  result consumed when valid&ready.
- rsp0_y / rsp1_y  output  36 each  unsigned product; 9x9 result in [17:0], [35:18] = 0.
- mult_A, mult_B  output  18 each  to core operands.
- mult_MODE  output  1  to core MODE.
- mult_Y  input  36  from core; 9x9 lanes: low lane in [17:0], high lane in [35:18].
- busy  output  1  operation in flight.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM = IDLE, RR pointer favours req0. An in-flight operation is discarded; both response buffers are cleared.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on any accepted request.
  - RUN counts PIPE_STAGES cycles, samples mult_Y on the last RUN cycle, then returns to IDLE.
- reqN_ready is combinational: state==IDLE, rspN_valid==0, and reqN is the arbitration winner.
- Arbitration is round-robin over eligible requesters (valid and response buffer empty). The winner becomes lowest priority next time. A sole eligible requester always wins.
- Issue (handshake at cycle T):
  - At T+1, mult_A/mult_B/mult_MODE are registered from the winner.
  - 18x18 request: operands passed whole, MODE=0.
  - 9x9 request: operand bits [8:0] placed in the low lane, high lane zeroed, MODE=1.
- Capture:
  - mult_Y is sampled at the end of cycle T+PIPE_STAGES.
  - rspN_y and rspN_valid are set at T+PIPE_STAGES+1. In 9x9 mode only the low lane is copied, upper bits zero.
- Latency from handshake to rsp_valid is PIPE_STAGES+1 (2 by default). Throughput is one operation per PIPE_STAGES+1 cycles.
- Response buffer: one entry per requester.
  - rspN_valid and rspN_y hold until rspN_ready. Clearing happens on that edge.
  - Requester N is ineligible while its buffer is full, so results are never overwritten.
  - Back-pressure on one requester does not block the other.
- mult_A/B/MODE hold their last issued values while IDLE (no toggling); busy = (state==RUN).
- Simultaneous rsp handshake and new capture for the same requester cannot occur: eligibility requires an empty buffer.
- Reset asserted mid-RUN: operation is dropped, no response is produced, and ready stays 0 while Reset_n is low.

Optional Feature:
- Macro: MULT_SHARE_ARB_PACK_EN.
- Defined:
  - In IDLE, when both requesters are eligible and both req_mode=1, both readys assert in the same cycle.
  - One MODE=1 operation carries req0 in the low lane and req1's [8:0] in the high lane.
  - Capture delivers mult_Y[17:0] to rsp0_y and mult_Y[35:18] to rsp1_y in the same cycle.
  - The RR pointer is unchanged.
- Undefined: the two 9x9 requests are serialised by normal round-robin; the high lane is always zero.

Test Plan:
- Reset: Reset_n low mid-RUN, then release -> all outputs 0, no stale rsp_valid, first request after release returns correct result.
- Single 18x18: req0 a=18'h3FFFF, b=18'h3FFFF, PIPE_STAGES=1 -> rsp0_valid 2 cycles after handshake, rsp0_y=36'hFFFF80001, mult_MODE=0.
- Round-robin: req0 and req1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; each product matches its operands.
- Back-pressure: rsp0_ready=0 with result held, req0 and req1 valid -> req0_ready=0, req1 served, rsp0_y stable until rsp0_ready=1.
- 9x9 without pack: req0 a=9'd511, b=9'd511 -> mult_MODE=1, rsp0_y=36'd261121, rsp0_y[35:18]=0.
- Pack (MULT_SHARE_ARB_PACK_EN): req0 9x9 3*5 and req1 9x9 7*11 in the same cycle -> both ready same cycle, single RUN, rsp0_y=15 and rsp1_y=77 valid in the same cycle.

Source files
------------

// File: rtl/mult_18x18_share_arbiter.sv
// mult_18x18_share_arbiter
//
// Shares one fracturable 18x18 multiplier core between two requesters.
// Each accepted request registers its operands onto the core, waits
// PIPE_STAGES cycles, samples the core product and parks it in a
// one-entry response buffer owned by that requester. A requester whose
// buffer is still full is not eligible, so results are never overwritten
// and back-pressure on one side never stalls the other.
//
// Optional feature (compile-time macro MULT_SHARE_ARB_PACK_EN):
//   When both requesters are eligible in the same idle cycle and both ask
//   for a 9x9 product, they are issued together as one MODE=1 operation
//   (req0 in the low lane, req1 in the high lane). Without the macro the
//   high lane is always zero and 9x9 requests are serialised.
//
// Parameters:
//   PIPE_STAGES  cycles from registered operands to a valid mult_Y (1..4)
//
// Ports:
//   clk, Reset_n            user clock, async active-low reset
//   reqN_valid/ready        request handshake (ready is combinational)
//   reqN_mode               0 = 18x18, 1 = 9x9 on bits [8:0]
//   reqN_a, reqN_b          unsigned 18-bit operands
//   rspN_valid/ready        response handshake, result held until consumed
//   rspN_y                  36-bit product (9x9 result in [17:0])
//   mult_A, mult_B          operands to the core
//   mult_MODE               core mode (0 = 18x18, 1 = dual 9x9)
//   mult_Y                  product from the core
//   busy                    an operation is in flight

module mult_18x18_share_arbiter #(
   parameter int unsigned PIPE_STAGES = 1
) (
   input  logic        clk,
   input  logic        Reset_n,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_mode,
   input  logic [17:0] req0_a,
   input  logic [17:0] req0_b,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_mode,
   input  logic [17:0] req1_a,
   input  logic [17:0] req1_b,

   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [35:0] rsp0_y,

   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [35:0] rsp1_y,

   output logic [17:0] mult_A,
   output logic [17:0] mult_B,
   output logic        mult_MODE,
   input  logic [35:0] mult_Y,

   output logic        busy
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   // Index of the final RUN cycle; the core product is sampled at its end.
   localparam logic [1:0] CntLast = 2'(PIPE_STAGES - 1);

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        rr_q, rr_d;          // 0: req0 has priority, 1: req1 has priority
   logic        own0_q, own0_d;      // in-flight operation delivers to rsp0
   logic        own1_q, own1_d;      // in-flight operation delivers to rsp1
   logic        op_mode_q, op_mode_d;
   logic [17:0] mult_a_q, mult_a_d;
   logic [17:0] mult_b_q, mult_b_d;
   logic        mult_mode_q, mult_mode_d;
   logic        rsp0_valid_q, rsp0_valid_d;
   logic        rsp1_valid_q, rsp1_valid_d;
   logic [35:0] rsp0_y_q, rsp0_y_d;
   logic [35:0] rsp1_y_q, rsp1_y_d;

   logic        elig0, elig1;
   logic        win0, win1;
   logic        pack_sel;
   logic        grant0, grant1;
   logic        issue;
   logic        run_last;
   logic        sel1;
   logic        sel_mode;
   logic [17:0] sel_a, sel_b;
   logic [35:0] lane_lo;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   always_comb begin
      elig0 = req0_valid & ~rsp0_valid_q;
      elig1 = req1_valid & ~rsp1_valid_q;
      // req1 wins when it is the only candidate or it holds priority.
      win1  = elig1 & (~elig0 | rr_q);
      win0  = elig0 & ~win1;
`ifdef MULT_SHARE_ARB_PACK_EN
      pack_sel = elig0 & elig1 & req0_mode & req1_mode;
`else
      pack_sel = 1'b0;
`endif
      // Gate with Reset_n so nothing is accepted while reset is held.
      grant0 = Reset_n & (state_q == StIdle) & (win0 | pack_sel);
      grant1 = Reset_n & (state_q == StIdle) & (win1 | pack_sel);
      issue  = grant0 | grant1;
      run_last = (state_q == StRun) && (cnt_q == CntLast);
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (issue)    state_d = StRun;
         StRun:   if (run_last) state_d = StIdle;
         default:               state_d = StIdle;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      busy       = (state_q == StRun);
      req0_ready = grant0;
      req1_ready = grant1;
   end

   // ------------------------------------------------------------------
   // Datapath next state
   // ------------------------------------------------------------------
   always_comb begin
      sel1     = grant1 & ~grant0;
      sel_mode = sel1 ? req1_mode : req0_mode;
      sel_a    = sel1 ? req1_a : req0_a;
      sel_b    = sel1 ? req1_b : req0_b;
      // In 9x9 mode only the low lane of the core result belongs to the owner.
      lane_lo  = op_mode_q ? {18'd0, mult_Y[17:0]} : mult_Y;
   end

   always_comb begin
      cnt_d        = cnt_q;
      rr_d         = rr_q;
      own0_d       = own0_q;
      own1_d       = own1_q;
      op_mode_d    = op_mode_q;
      mult_a_d     = mult_a_q;
      mult_b_d     = mult_b_q;
      mult_mode_d  = mult_mode_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      rsp0_y_d     = rsp0_y_q;
      rsp1_y_d     = rsp1_y_q;

      if ((state_q == StRun) && !run_last) begin
         cnt_d = cnt_q + 2'd1;
      end

      if (issue) begin
         cnt_d  = 2'd0;
         own0_d = grant0;
         own1_d = grant1;
         if (pack_sel) begin
            // Both 9x9 requests share one operation; priority is left alone.
            mult_a_d    = {req1_a[8:0], req0_a[8:0]};
            mult_b_d    = {req1_b[8:0], req0_b[8:0]};
            mult_mode_d = 1'b1;
            op_mode_d   = 1'b1;
         end else begin
            mult_a_d    = sel_mode ? {9'd0, sel_a[8:0]} : sel_a;
            mult_b_d    = sel_mode ? {9'd0, sel_b[8:0]} : sel_b;
            mult_mode_d = sel_mode;
            op_mode_d   = sel_mode;
            // The winner drops to lowest priority.
            rr_d        = ~sel1;
         end
      end

      if (rsp0_valid_q && rsp0_ready) begin
         rsp0_valid_d = 1'b0;
         rsp0_y_d     = 36'd0;
      end
      if (rsp1_valid_q && rsp1_ready) begin
         rsp1_valid_d = 1'b0;
         rsp1_y_d     = 36'd0;
      end

      // An owner's buffer was empty at issue, so capture never races a consume.
      if (run_last) begin
         if (own0_q) begin
            rsp0_valid_d = 1'b1;
            rsp0_y_d     = lane_lo;
         end
         if (own1_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_y_d     = lane_lo;
`ifdef MULT_SHARE_ARB_PACK_EN
            if (own0_q) begin
               rsp1_y_d = {18'd0, mult_Y[35:18]};
            end
`endif
         end
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q        <= 2'd0;
         rr_q         <= 1'b0;
         own0_q       <= 1'b0;
         own1_q       <= 1'b0;
         op_mode_q    <= 1'b0;
         mult_a_q     <= 18'd0;
         mult_b_q     <= 18'd0;
         mult_mode_q  <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_y_q     <= 36'd0;
         rsp1_y_q     <= 36'd0;
      end else begin
         cnt_q        <= cnt_d;
         rr_q         <= rr_d;
         own0_q       <= own0_d;
         own1_q       <= own1_d;
         op_mode_q    <= op_mode_d;
         mult_a_q     <= mult_a_d;
         mult_b_q     <= mult_b_d;
         mult_mode_q  <= mult_mode_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_y_q     <= rsp0_y_d;
         rsp1_y_q     <= rsp1_y_d;
      end
   end

   assign mult_A     = mult_a_q;
   assign mult_B     = mult_b_q;
   assign mult_MODE  = mult_mode_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_y     = rsp0_y_q;
   assign rsp1_y     = rsp1_y_q;

endmodule

// File: tb/tb_mult_18x18_share_arbiter.sv
// Self-checking bench for mult_18x18_share_arbiter: directed vector table,
// hand-written corner sequences and a randomized phase, all cross-checked
// against a transaction-level reference model running every cycle.

module tb_mult_18x18_share_arbiter;

   localparam int unsigned P = 1;

   logic        clk = 1'b0;
   logic        Reset_n;
   logic        req0_valid, req0_ready, req0_mode;
   logic [17:0] req0_a, req0_b;
   logic        req1_valid, req1_ready, req1_mode;
   logic [17:0] req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready;
   logic [35:0] rsp0_y;
   logic        rsp1_valid, rsp1_ready;
   logic [35:0] rsp1_y;
   logic [17:0] mult_A, mult_B;
   logic        mult_MODE;
   logic [35:0] mult_Y;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int unsigned cyc = 0;
   int unsigned hs_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mult_18x18_share_arbiter #(.PIPE_STAGES(P)) dut (
      .clk        (clk),
      .Reset_n    (Reset_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_mode  (req0_mode),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_mode  (req1_mode),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_y     (rsp0_y),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_y     (rsp1_y),
      .mult_A     (mult_A),
      .mult_B     (mult_B),
      .mult_MODE  (mult_MODE),
      .mult_Y     (mult_Y),
      .busy       (busy)
   );

   // Behavioural fracturable core, combinational (PIPE_STAGES = 1).
   assign mult_Y = mult_MODE ?
      {18'(mult_A[17:9]) * 18'(mult_B[17:9]), 18'(mult_A[8:0]) * 18'(mult_B[8:0])} :
      36'(mult_A) * 36'(mult_B);

   task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [35:0] prod(input logic m, input logic [17:0] a,
                                        input logic [17:0] b);
      if (m) return 36'(a[8:0]) * 36'(b[8:0]);
      return 36'(a) * 36'(b);
   endfunction

   // ---------------- reference model (transaction level) ----------------
   typedef struct packed {
      logic [35:0] y;
      logic [31:0] due;
   } pend_t;

   pend_t       q0[$], q1[$];
   logic        m_full0 = 1'b0, m_full1 = 1'b0;
   logic [35:0] m_y0, m_y1;
   int unsigned m_next = 0;   // first cycle a new request may be accepted
   logic        m_rr = 1'b0;  // 1 when req1 holds priority
   logic [17:0] m_a = '0, m_b = '0;
   logic        m_mode = 1'b0;

   always @(negedge clk) begin
      logic e0, e1, w0, w1, idle, pk;
      if (Reset_n !== 1'b1) begin
         q0.delete();
         q1.delete();
         m_full0 = 1'b0;
         m_full1 = 1'b0;
         m_next  = 0;
         m_rr    = 1'b0;
         m_a     = '0;
         m_b     = '0;
         m_mode  = 1'b0;
         check("rst_req0_ready", 36'(req0_ready), 36'd0);
         check("rst_req1_ready", 36'(req1_ready), 36'd0);
         check("rst_rsp0_valid", 36'(rsp0_valid), 36'd0);
         check("rst_rsp1_valid", 36'(rsp1_valid), 36'd0);
         check("rst_busy", 36'(busy), 36'd0);
         check("rst_mult_A", 36'(mult_A), 36'd0);
      end else begin
         if (q0.size() > 0 && q0[0].due == cyc) begin
            m_full0 = 1'b1;
            m_y0    = q0[0].y;
            void'(q0.pop_front());
         end
         if (q1.size() > 0 && q1[0].due == cyc) begin
            m_full1 = 1'b1;
            m_y1    = q1[0].y;
            void'(q1.pop_front());
         end
         check("m_rsp0_valid", 36'(rsp0_valid), 36'(m_full0));
         check("m_rsp1_valid", 36'(rsp1_valid), 36'(m_full1));
         if (m_full0) check("m_rsp0_y", rsp0_y, m_y0);
         if (m_full1) check("m_rsp1_y", rsp1_y, m_y1);
         check("m_mult_A", 36'(mult_A), 36'(m_a));
         check("m_mult_B", 36'(mult_B), 36'(m_b));
         check("m_mult_MODE", 36'(mult_MODE), 36'(m_mode));

         idle = (cyc >= m_next);
         check("m_busy", 36'(busy), 36'(!idle));
         e0 = req0_valid & !m_full0;
         e1 = req1_valid & !m_full1;
`ifdef MULT_SHARE_ARB_PACK_EN
         pk = e0 & e1 & req0_mode & req1_mode;
`else
         pk = 1'b0;
`endif
         w1 = e1 & (!e0 | m_rr);
         w0 = e0 & !w1;
         if (pk) begin
            w0 = 1'b1;
            w1 = 1'b1;
         end
         if (!idle) begin
            w0 = 1'b0;
            w1 = 1'b0;
         end
         check("m_req0_ready", 36'(req0_ready), 36'(w0));
         check("m_req1_ready", 36'(req1_ready), 36'(w1));

         if (m_full0 && rsp0_ready) m_full0 = 1'b0;
         if (m_full1 && rsp1_ready) m_full1 = 1'b0;

         if (w0 | w1) begin
            m_next = cyc + P + 1;
            if (pk) begin
               q0.push_back('{y: prod(1'b1, req0_a, req0_b), due: cyc + P + 1});
               q1.push_back('{y: prod(1'b1, req1_a, req1_b), due: cyc + P + 1});
               m_a    = {req1_a[8:0], req0_a[8:0]};
               m_b    = {req1_b[8:0], req0_b[8:0]};
               m_mode = 1'b1;
            end else if (w0) begin
               q0.push_back('{y: prod(req0_mode, req0_a, req0_b), due: cyc + P + 1});
               m_a    = req0_mode ? {9'd0, req0_a[8:0]} : req0_a;
               m_b    = req0_mode ? {9'd0, req0_b[8:0]} : req0_b;
               m_mode = req0_mode;
               m_rr   = 1'b1;
            end else begin
               q1.push_back('{y: prod(req1_mode, req1_a, req1_b), due: cyc + P + 1});
               m_a    = req1_mode ? {9'd0, req1_a[8:0]} : req1_a;
               m_b    = req1_mode ? {9'd0, req1_b[8:0]} : req1_b;
               m_mode = req1_mode;
               m_rr   = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus helpers (start and end at posedge+1) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit who, input logic m, input logic [17:0] a,
                       input logic [17:0] b);
      int n;
      if (!who) begin
         req0_valid = 1'b1; req0_mode = m; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_mode = m; req1_a = a; req1_b = b;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(who ? req1_ready : req0_ready) && n < 20);
      check("send_handshake", 36'(n < 20), 36'd1);
      hs_cyc = cyc;
      tick();
      if (!who) req0_valid = 1'b0;
      else req1_valid = 1'b0;
   endtask

   typedef struct {
      bit          who;
      logic        m;
      logic [17:0] a;
      logic [17:0] b;
      logic [35:0] y;
   } vec_t;

   task automatic run_one(input vec_t v);
      int n;
      send(v.who, v.m, v.a, v.b);
      n = 0;
      while (!(v.who ? rsp1_valid : rsp0_valid) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rsp_wait", 36'(n < 20), 36'd1);
      check("latency", 36'(cyc - hs_cyc), 36'(P + 1));
      check("rsp_y", v.who ? rsp1_y : rsp0_y, v.y);
      check("mult_mode", 36'(mult_MODE), 36'(v.m));
      tick();
      if (!v.who) rsp0_ready = 1'b1;
      else rsp1_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
   endtask

   function automatic logic [17:0] rnd18();
      case ($urandom_range(0, 7))
         0:       return 18'h3FFFF;
         1:       return 18'h00000;
         default: return 18'($urandom);
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      vec_t vecs[7];
      vec_t v;
      int   g[8];
      int   ng, n, n1;
      logic got0, got1;

      vecs[0] = '{1'b0, 1'b0, 18'h3FFFF, 18'h3FFFF, 36'hFFFF80001};
      vecs[1] = '{1'b1, 1'b0, 18'd1000,  18'd2000,  36'd2000000};
      vecs[2] = '{1'b0, 1'b1, 18'd511,   18'd511,   36'd261121};
      vecs[3] = '{1'b1, 1'b1, 18'h3FE05, 18'h20203, 36'd15};
      vecs[4] = '{1'b0, 1'b0, 18'h20000, 18'd2,     36'h40000};
      vecs[5] = '{1'b1, 1'b0, 18'd0,     18'h3FFFF, 36'd0};
      vecs[6] = '{1'b1, 1'b1, 18'h3FFFF, 18'h3FFFF, 36'd261121};

      Reset_n    = 1'b1;
      req0_valid = 1'b0; req0_mode = 1'b0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_mode = 1'b0; req1_a = '0; req1_b = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #2 Reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_mult_A", 36'(mult_A), 36'd0);
      check("reset_mult_B", 36'(mult_B), 36'd0);
      check("reset_mult_MODE", 36'(mult_MODE), 36'd0);
      check("reset_rsp0_y", rsp0_y, 36'd0);
      check("reset_rsp1_y", rsp1_y, 36'd0);
      check("reset_busy", 36'(busy), 36'd0);
      Reset_n = 1'b1;
      tick();

      // Directed vector table.
      for (int i = 0; i < 7; i++) begin
         run_one(vecs[i]);
      end

      // Round-robin alternation with both requesters always valid.
      req0_mode = 1'b0; req0_a = 18'd123; req0_b = 18'd456;
      req1_mode = 1'b0; req1_a = 18'd789; req1_b = 18'd1011;
      req0_valid = 1'b1; req1_valid = 1'b1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      ng = 0;
      n  = 0;
      while (ng < 8 && n < 60) begin
         @(negedge clk);
         n++;
         if (req0_ready) begin
            g[ng] = 0;
            ng++;
         end else if (req1_ready) begin
            g[ng] = 1;
            ng++;
         end
      end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("rr_grant_count", 36'(ng), 36'd8);
      for (int i = 1; i < 8; i++) begin
         check("rr_alternate", 36'(g[i]), 36'(1 - g[i-1]));
      end
      repeat (4) tick();

      // Back-pressure on rsp0 must not block req1.
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      send(1'b0, 1'b0, 18'd300, 18'd400);
      n = 0;
      while (!rsp0_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bp_rsp0_wait", 36'(n < 20), 36'd1);
      check("bp_rsp0_y", rsp0_y, 36'd120000);
      tick();
      req0_valid = 1'b1; req0_mode = 1'b0; req0_a = 18'd5; req0_b = 18'd5;
      req1_valid = 1'b1; req1_mode = 1'b0; req1_a = 18'd9; req1_b = 18'd9;
      n1 = 0;
      repeat (6) begin
         @(negedge clk);
         check("bp_req0_blocked", 36'(req0_ready), 36'd0);
         check("bp_rsp0_stable", rsp0_y, 36'd120000);
         if (req1_ready) n1++;
      end
      check("bp_req1_served", 36'(n1 > 0), 36'd1);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      tick();
      check("bp_rsp0_cleared", 36'(rsp0_valid), 36'd0);
      repeat (3) tick();

      // Reset in the middle of RUN drops the operation.
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      send(1'b0, 1'b0, 18'd1000, 18'd1000);
      check("mr_busy", 36'(busy), 36'd1);
      Reset_n    = 1'b0;
      req0_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("mr_ready_low", 36'(req0_ready), 36'd0);
         check("mr_no_rsp", 36'(rsp0_valid), 36'd0);
      end
      tick();
      req0_valid = 1'b0;
      Reset_n    = 1'b1;
      repeat (3) tick();
      check("mr_no_stale_rsp", 36'(rsp0_valid), 36'd0);
      check("mr_idle", 36'(busy), 36'd0);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      v = '{1'b0, 1'b0, 18'd12345, 18'd678, 36'd8369910};
      run_one(v);

`ifdef MULT_SHARE_ARB_PACK_EN
      // Two 9x9 requests packed into one operation.
      req0_valid = 1'b1; req0_mode = 1'b1; req0_a = 18'd3; req0_b = 18'd5;
      req1_valid = 1'b1; req1_mode = 1'b1; req1_a = 18'd7; req1_b = 18'd11;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(req0_ready | req1_ready) && n < 20);
      check("pk_both_ready", 36'({req0_ready, req1_ready}), 36'd3);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      n = 0;
      while (!rsp0_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("pk_rsp0_valid", 36'(rsp0_valid), 36'd1);
      check("pk_rsp1_same_cycle", 36'(rsp1_valid), 36'd1);
      check("pk_rsp0_y", rsp0_y, 36'd15);
      check("pk_rsp1_y", rsp1_y, 36'd77);
      tick();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      tick();
`else
      // Without packing, two 9x9 requests are served one at a time.
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_mode = 1'b1; req0_a = 18'd3; req0_b = 18'd5;
      req1_valid = 1'b1; req1_mode = 1'b1; req1_a = 18'd7; req1_b = 18'd11;
      got0 = 1'b0;
      got1 = 1'b0;
      n = 0;
      while (!(got0 && got1) && n < 30) begin
         @(negedge clk);
         n++;
         check("ser_not_both", 36'(req0_ready & req1_ready), 36'd0);
         if (rsp1_valid) check("ser_high_lane_zero", 36'(rsp1_y[35:18]), 36'd0);
         if (req0_ready) got0 = 1'b1;
         if (req1_ready) got1 = 1'b1;
      end
      check("ser_both_served", 36'(got0 & got1), 36'd1);
      tick();
`endif
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      repeat (4) tick();

      // Randomized traffic, checked by the reference model.
      for (int i = 0; i < 400; i++) begin
         req0_valid = ($urandom_range(0, 9) < 6);
         req1_valid = ($urandom_range(0, 9) < 6);
         req0_mode  = 1'($urandom_range(0, 1));
         req1_mode  = 1'($urandom_range(0, 1));
         req0_a     = rnd18();
         req0_b     = rnd18();
         req1_a     = rnd18();
         req1_b     = rnd18();
         rsp0_ready = ($urandom_range(0, 9) < 7);
         rsp1_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (10) tick();
      check("drain_q0", 36'(q0.size()), 36'd0);
      check("drain_q1", 36'(q1.size()), 36'd0);
      check("drain_rsp0", 36'(rsp0_valid), 36'd0);
      check("drain_rsp1", 36'(rsp1_valid), 36'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
